// File: rtl/if_window_sequencer.sv
// Sequences the circular IF scratchpad: fills it from the IF stream,
// then replays each K-long filter window to the MAC stage and slides by S.
module if_window_sequencer #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_LEN-1:0] filt_len,
  input  logic [ADDR_LEN-1:0] stride,
  input  logic [CNT_W-1:0]    num_windows,
  input  logic                if_valid,
  output logic                if_ready,
  output logic                wr_en,
  output logic [ADDR_LEN-1:0] wr_addr,
  input  logic                mac_ready,
  output logic                rd_en,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic                win_first,
  output logic                win_last,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_LEN:0] DEPTH = (ADDR_LEN+1)'(SCRATCH_DEPTH);
  localparam logic [ADDR_LEN:0] LAST  = DEPTH - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_ADV,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_LEN-1:0] wr_ptr, base, offset;
  logic [ADDR_LEN-1:0] k_r, s_r;
  logic [CNT_W-1:0]    win_cnt, n_r;
  logic [ADDR_LEN-1:0] k_sat, s_sat;
  logic [ADDR_LEN:0]   occ;
  logic                last_off;
  logic                launch;

  function automatic logic [ADDR_LEN-1:0] wrap_add(
    input logic [ADDR_LEN-1:0] a,
    input logic [ADDR_LEN-1:0] b
  );
    logic [ADDR_LEN:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= DEPTH) sum = sum - DEPTH;
    return sum[ADDR_LEN-1:0];
  endfunction

  // Clamp config so a window always fits with one slot kept free
  always_comb begin
    k_sat = filt_len;
    if (filt_len == '0)
      k_sat = ADDR_LEN'(1);
    else if ({1'b0, filt_len} > LAST)
      k_sat = LAST[ADDR_LEN-1:0];
    s_sat = stride;
    if (stride == '0)
      s_sat = ADDR_LEN'(1);
    else if (stride > k_sat)
      s_sat = k_sat;
  end

  always_comb begin
    if (base > wr_ptr)
      occ = DEPTH - ({1'b0, base} - {1'b0, wr_ptr});
    else
      occ = {1'b0, wr_ptr} - {1'b0, base};
  end

  assign last_off = (offset == k_r - 1'b1);
  assign launch   = (state == S_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_nxt = (num_windows == '0) ? S_DONE : S_WAIT;
      S_WAIT:
        if (occ >= {1'b0, k_r}) state_nxt = S_READ;
      S_READ:
        if (mac_ready && last_off) state_nxt = S_ADV;
      S_ADV:
        if ({1'b0, win_cnt} + 1'b1 == {1'b0, n_r})
          state_nxt = S_DONE;
        else
          state_nxt = S_WAIT;
      S_DONE:
        state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    if_ready  = busy && (occ < LAST);
    wr_en     = if_valid && if_ready;
    wr_addr   = wr_ptr;
    rd_en     = (state == S_READ) && mac_ready;
    rd_addr   = wrap_add(base, offset);
    win_first = rd_en && (offset == '0);
    win_last  = rd_en && last_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      base    <= '0;
      offset  <= '0;
      win_cnt <= '0;
      k_r     <= '0;
      s_r     <= '0;
      n_r     <= '0;
    end else if (launch) begin
      k_r     <= k_sat;
      s_r     <= s_sat;
      n_r     <= num_windows;
      wr_ptr  <= '0;
      base    <= '0;
      offset  <= '0;
      win_cnt <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wrap_add(wr_ptr, ADDR_LEN'(1));
      if (rd_en)
        offset <= last_off ? '0 : offset + 1'b1;
      // Base slide and a same-cycle write both land
      if (state == S_ADV) begin
        base    <= wrap_add(base, s_r);
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_window_sequencer.sv
// Scoreboard bench for if_window_sequencer: directed passes with
// expected read/done events queued and checked by a monitor.
module tb_if_window_sequencer;

  localparam int AW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] filt_len = '0;
  logic [AW-1:0] stride = '0;
  logic [CW-1:0] num_windows = '0;
  logic          if_valid = 1'b0;
  logic          mac_ready = 1'b0;
  logic          if_ready, wr_en, rd_en;
  logic          win_first, win_last, busy, done;
  logic [AW-1:0] wr_addr, rd_addr;

  if_window_sequencer #(
    .ADDR_LEN(AW), .SCRATCH_DEPTH(16), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .filt_len(filt_len), .stride(stride),
    .num_windows(num_windows),
    .if_valid(if_valid), .if_ready(if_ready),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .mac_ready(mac_ready), .rd_en(rd_en),
    .rd_addr(rd_addr), .win_first(win_first),
    .win_last(win_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int addr;
    bit first;
    bit last;
  } ev_t;

  ev_t sb[$];
  ev_t e;
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void push_rd(input int a, input bit f, input bit l);
    ev_t x;
    x.is_done = 1'b0; x.addr = a; x.first = f; x.last = l;
    sb.push_back(x);
  endfunction

  function automatic void push_done();
    ev_t x;
    x.is_done = 1'b1; x.addr = 0; x.first = 1'b0; x.last = 1'b0;
    sb.push_back(x);
  endfunction

  function automatic void push_win(input int b, input int k);
    for (int o = 0; o < k; o++)
      push_rd((b + o) % 16, o == 0, o == k - 1);
  endfunction

  // Monitor: every presented read or done must match the queue head
  always @(negedge clk) begin
    if (!rst && rd_en) begin
      if (sb.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("rd_kind", 0, int'(e.is_done));
        check("rd_addr", int'(rd_addr), e.addr);
        check("win_first", int'(win_first), int'(e.first));
        check("win_last", int'(win_last), int'(e.last));
      end
    end
    if (!rst && done) begin
      if (sb.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("done_kind", 1, int'(e.is_done));
      end
    end
  end

  task automatic pulse_start(input int k, input int s, input int n);
    @(posedge clk); #1;
    filt_len = AW'(k); stride = AW'(s);
    num_windows = CW'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_timed(input int budget,
                           output int first_rd, output int dn);
    first_rd = 0; dn = 0;
    for (int c = 1; c <= budget && dn == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_c1", int'(busy), 1);
        check("if_ready_c1", int'(if_ready), 1);
        check("wr_addr_c1", int'(wr_addr), 0);
      end
      if (rd_en && first_rd == 0) first_rd = c;
      if (done) dn = c;
    end
  endtask

  task automatic wait_done(input int budget, output int dn);
    dn = 0;
    for (int c = 1; c <= budget && dn == 0; c++) begin
      @(negedge clk);
      if (done) dn = c;
    end
  endtask

  task automatic end_pass(input string nm, input int dn);
    if (dn == 0) check({nm, "_done_timeout"}, 0, 1);
    @(negedge clk);
    check({nm, "_busy_after"}, int'(busy), 0);
    check({nm, "_sb_empty"}, sb.size(), 0);
  endtask

  function automatic int out_vec();
    return int'({if_ready, wr_en, wr_addr, rd_en, rd_addr,
                 win_first, win_last, busy, done});
  endfunction

  int  fr, dn;
  bit  found;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // K=3 S=1 N=2
    if_valid = 1'b1; mac_ready = 1'b1;
    push_rd(0, 1, 0); push_rd(1, 0, 0); push_rd(2, 0, 1);
    push_rd(1, 1, 0); push_rd(2, 0, 0); push_rd(3, 0, 1);
    push_done();
    pulse_start(3, 1, 2);
    run_timed(60, fr, dn);
    check("t1_first_rd_cycle", fr, 5);
    check("t1_done_cycle", dn, 14);
    end_pass("t1", dn);

    // K=4 S=4 N=5 wraps the base back to 0
    push_win(0, 4); push_win(4, 4); push_win(8, 4);
    push_win(12, 4); push_win(0, 4);
    push_done();
    pulse_start(4, 4, 5);
    run_timed(300, fr, dn);
    check("t2_first_rd_cycle", fr, 6);
    end_pass("t2", dn);

    // K=4 S=1 N=3 with MAC stalled: scratchpad fills to 15
    mac_ready = 1'b0;
    push_win(0, 4); push_win(1, 4); push_win(2, 4);
    push_done();
    pulse_start(4, 1, 3);
    repeat (20) @(negedge clk);
    check("t3_full_if_ready", int'(if_ready), 0);
    check("t3_full_wr_en", int'(wr_en), 0);
    check("t3_full_wr_addr", int'(wr_addr), 15);
    check("t3_stall_rd_en", int'(rd_en), 0);
    @(posedge clk); #1;
    mac_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (rd_en && win_last) found = 1'b1;
    end
    check("t3_first_win_end", int'(found), 1);
    @(negedge clk);
    check("t3_adv_if_ready", int'(if_ready), 0);
    @(negedge clk);
    check("t3_post_adv_if_ready", int'(if_ready), 1);
    wait_done(80, dn);
    end_pass("t3", dn);

    // N=0: one DONE cycle, no traffic
    if_valid = 1'b0;
    push_done();
    pulse_start(3, 1, 0);
    @(negedge clk);
    check("t4_busy", int'(busy), 1);
    check("t4_done", int'(done), 1);
    check("t4_rd_en", int'(rd_en), 0);
    check("t4_wr_en", int'(wr_en), 0);
    end_pass("t4", 1);

    // stride 0 behaves as 1
    if_valid = 1'b1;
    push_rd(0, 1, 0); push_rd(1, 0, 1);
    push_rd(1, 1, 0); push_rd(2, 0, 1);
    push_done();
    pulse_start(2, 0, 2);
    run_timed(60, fr, dn);
    check("t5_first_rd_cycle", fr, 4);
    check("t5_done_cycle", dn, 11);
    end_pass("t5", dn);

    // reset mid-READ at offset 1
    push_rd(0, 1, 0);
    pulse_start(3, 1, 2);
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (rd_en) found = 1'b1;
    end
    check("t6_reached_read", int'(found), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_outputs", out_vec(), 0);
    check("t6_sb_empty", sb.size(), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    found = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) found = 1'b1;
    end
    check("t6_no_done_after_rst", int'(found), 0);

    push_rd(0, 1, 0); push_rd(1, 0, 1);
    push_done();
    pulse_start(2, 1, 1);
    run_timed(40, fr, dn);
    check("t6b_first_rd_cycle", fr, 4);
    check("t6b_done_cycle", dn, 7);
    end_pass("t6b", dn);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
